mdu_scheduler: RTL

Sequencing and arbitration controller for the shared multiply/divide unit (one signed/unsigned multiplier, one divider) in the dual-issue core. It accepts MULT/MULTU/DIV/DIVU requests from both issue slots, grants one at a time, launches it on the correct unit and tracks completion through the units' level-sensitive `done` outputs. It emits a single HI/LO write pulse with the 64-bit result and generates pipeline stalls for blocked requests and early HI/LO reads. It sits between the two execute stages and the multiplier/divider instances.

---
 rtl/mdu_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mdu_scheduler.sv
// Multiply/divide unit scheduler: arbitrates two issue slots, launches one op at a time
// and commits a single HI/LO write. Define MDU_FLUSH_ABORT_EN to let flush abort an op in WAIT.
module mdu_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [1:0]  req_valid_i,
    input  logic [1:0]  req0_op_i,
    input  logic [1:0]  req1_op_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    output logic [1:0]  req_grant_o,
    input  logic [1:0]  hilo_rd_i,
    output logic        stall_o,
    output logic [1:0]  mult_op_o,
    output logic [1:0]  div_op_o,
    output logic [31:0] unit_a_o,
    output logic [31:0] unit_b_o,
    input  logic        mult_done_i,
    input  logic        div_done_i,
    input  logic [63:0] mult_res_i,
    input  logic [63:0] div_res_i,
    output logic        hilo_wen_o,
    output logic [63:0] hilo_wdata_o,
    output logic        busy_o
);

`ifdef MDU_FLUSH_ABORT_EN
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_COMMIT, S_DRAIN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_COMMIT} state_t;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_op;
    logic        r_seen_low;
    logic [1:0]  w_grant;
    logic        w_done_sel;
    logic        w_complete;
    logic        w_tracking;

    assign w_done_sel = r_op[1] ? div_done_i : mult_done_i;
    // A done level only counts once it has been seen low since launch.
    assign w_complete = w_done_sel && r_seen_low;

`ifdef MDU_FLUSH_ABORT_EN
    assign w_tracking = (r_state == S_WAIT) || (r_state == S_DRAIN);
`else
    assign w_tracking = (r_state == S_WAIT);
`endif

    always_comb begin
        w_grant = '0;
        if (!rst && r_state == S_IDLE && !flush_i) begin
            if (req_valid_i[0])
                w_grant = 2'b01;
            else if (req_valid_i[1])
                w_grant = 2'b10;
        end
    end

    assign req_grant_o = w_grant;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (|w_grant) w_next = S_LAUNCH;
            S_LAUNCH: w_next = flush_i ? S_IDLE : S_WAIT;
            S_WAIT: begin
`ifdef MDU_FLUSH_ABORT_EN
                if (flush_i)
                    w_next = S_DRAIN;
                else
`endif
                if (w_complete)
                    w_next = S_COMMIT;
            end
            S_COMMIT: w_next = S_IDLE;
`ifdef MDU_FLUSH_ABORT_EN
            S_DRAIN:  if (w_complete) w_next = S_IDLE;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op         <= '0;
            unit_a_o     <= '0;
            unit_b_o     <= '0;
            hilo_wdata_o <= '0;
            r_seen_low   <= 1'b0;
        end else begin
            if (w_grant[0]) begin
                r_op     <= req0_op_i;
                unit_a_o <= req0_a_i;
                unit_b_o <= req0_b_i;
            end else if (w_grant[1]) begin
                r_op     <= req1_op_i;
                unit_a_o <= req1_a_i;
                unit_b_o <= req1_b_i;
            end
            if (r_state == S_LAUNCH)
                r_seen_low <= 1'b0;
            else if (w_tracking && !w_done_sel)
                r_seen_low <= 1'b1;
            if (r_state == S_WAIT && w_next == S_COMMIT)
                hilo_wdata_o <= r_op[1] ? div_res_i : mult_res_i;
        end
    end

    always_comb begin
        mult_op_o = '0;
        div_op_o  = '0;
        if (!rst && r_state == S_LAUNCH && !flush_i) begin
            if (r_op[1])
                div_op_o  = r_op[0] ? 2'b01 : 2'b10;
            else
                mult_op_o = r_op[0] ? 2'b01 : 2'b10;
        end
        hilo_wen_o = !rst && (r_state == S_COMMIT);
        busy_o     = (r_state != S_IDLE);
        stall_o    = !rst && ((|(req_valid_i & ~w_grant))
                           || ((|hilo_rd_i) && r_state != S_IDLE)
                           || (|w_grant));
    end

endmodule
